// File: rtl/window_3_3_gen.sv
// 3x3 sliding-window generator: raster pixels in, one packed 3x3 window out per interior position.
// Optional WIN_LAST end-of-frame window marker is enabled by defining WINDOW_3_3_GEN_WIN_LAST_EN.
module window_3_3_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      PIX_VALID,
  input  logic [DATA_WIDTH-1:0]     PIX_DATA,
  output logic                      PIX_READY,
  output logic                      WIN_VALID,
  input  logic                      WIN_READY,
  output logic [DATA_WIDTH*9-1:0]   Feature_out,
  output logic                      FRAME_DONE
`ifdef WINDOW_3_3_GEN_WIN_LAST_EN
  ,
  output logic                      WIN_LAST
`endif
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0]              col_q, col_d;
  logic [RW-1:0]              row_q, row_d;
  logic [DATA_WIDTH-1:0]      lb0_q [IMG_WIDTH];
  logic [DATA_WIDTH-1:0]      lb1_q [IMG_WIDTH];
  logic [DATA_WIDTH-1:0]      win_q [3][2];
  logic [DATA_WIDTH-1:0]      win_d [3][2];
  logic [DATA_WIDTH-1:0]      new_col [3];
  logic [DATA_WIDTH*9-1:0]    window;
  logic [DATA_WIDTH*9-1:0]    feature_q, feature_d;
  logic                       win_valid_q, win_valid_d;
  logic                       frame_done_q, frame_done_d;
  logic                       accept, emit, last_pix;

  // Handshakes: a beat moves when valid && ready in the same cycle; valid and
  // its data hold until taken, and ready never depends on the matching valid.
  assign PIX_READY   = !win_valid_q || WIN_READY;
  assign accept      = PIX_VALID && PIX_READY;
  assign last_pix    = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign emit        = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign WIN_VALID   = win_valid_q;
  assign Feature_out = feature_q;
  assign FRAME_DONE  = frame_done_q;

  always_comb begin
    new_col[0] = lb1_q[col_q];
    new_col[1] = lb0_q[col_q];
    new_col[2] = PIX_DATA;
    window     = '0;
    // Row 0 is the oldest line; column 2 is the pixel column arriving now.
    for (int r = 0; r < 3; r++) begin
      window[DATA_WIDTH*(r*3+0) +: DATA_WIDTH] = win_q[r][0];
      window[DATA_WIDTH*(r*3+1) +: DATA_WIDTH] = win_q[r][1];
      window[DATA_WIDTH*(r*3+2) +: DATA_WIDTH] = new_col[r];
    end
  end

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    feature_d    = feature_q;
    win_valid_d  = win_valid_q;
    frame_done_d = accept && last_pix;
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = new_col[r];
      end
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
    if (emit) begin
      win_valid_d = 1'b1;
      feature_d   = window;
    end else if (WIN_READY) begin
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '{default: '0};
      feature_q    <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      feature_q    <= feature_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line contents are never reset: the row counter decides when they are meaningful.
  always_ff @(posedge CLK) begin
    if (accept) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= PIX_DATA;
    end
  end

`ifdef WINDOW_3_3_GEN_WIN_LAST_EN
  logic win_last_q, win_last_d;

  always_comb begin
    win_last_d = win_last_q;
    if (emit) begin
      win_last_d = last_pix;
    end else if (WIN_READY) begin
      win_last_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      win_last_q <= 1'b0;
    end else begin
      win_last_q <= win_last_d;
    end
  end

  assign WIN_LAST = win_last_q;
`endif

endmodule

// File: tb/tb_window_3_3_gen.sv
// Bench for window_3_3_gen on a 4x4 image: directed frames, stall, reset and randomized traffic
// checked against an image-array reference model.
module tb_window_3_3_gen;

  localparam int DW = 8;
  localparam int IW = 4;
  localparam int IH = 4;
  localparam int FW = DW * 9;

  logic          CLK;
  logic          RST;
  logic          PIX_VALID;
  logic [DW-1:0] PIX_DATA;
  logic          PIX_READY;
  logic          WIN_VALID;
  logic          WIN_READY;
  logic [FW-1:0] Feature_out;
  logic          FRAME_DONE;
`ifdef WINDOW_3_3_GEN_WIN_LAST_EN
  logic          WIN_LAST;
`endif

  window_3_3_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)) dut (
    .CLK(CLK),
    .RST(RST),
    .PIX_VALID(PIX_VALID),
    .PIX_DATA(PIX_DATA),
    .PIX_READY(PIX_READY),
    .WIN_VALID(WIN_VALID),
    .WIN_READY(WIN_READY),
    .Feature_out(Feature_out),
    .FRAME_DONE(FRAME_DONE)
`ifdef WINDOW_3_3_GEN_WIN_LAST_EN
    ,
    .WIN_LAST(WIN_LAST)
`endif
  );

  // Clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk_win(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic got, input logic exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Reference model and scoreboard
  logic [DW-1:0] img [IH][IW];
  logic [FW-1:0] exp_q [$];
  logic          exp_last_q [$];
  logic [FW-1:0] got_q [$];
  int            m_row = 0;
  int            m_col = 0;
  int            fd_cnt = 0;
  bit            post_reset = 0;
  bit            new_pend = 0;
  bit            hold_pend = 0;
  bit            fd_exp = 0;
  logic [FW-1:0] new_val;
  logic [FW-1:0] hold_val;

  always @(negedge CLK) begin
    logic [FW-1:0] w;
    logic          lst;
    if (RST) begin
      m_row = 0;
      m_col = 0;
      exp_q.delete();
      exp_last_q.delete();
      new_pend   = 0;
      hold_pend  = 0;
      fd_exp     = 0;
      post_reset = 1;
    end else begin
      if (post_reset) begin
        chk_win("rst_feature", Feature_out, '0);
        chk_bit("rst_win_valid", WIN_VALID, 1'b0);
        chk_bit("rst_frame_done", FRAME_DONE, 1'b0);
        chk_bit("rst_pix_ready", PIX_READY, 1'b1);
        post_reset = 0;
      end
      chk_bit("pix_ready", PIX_READY, !WIN_VALID || WIN_READY);
      chk_bit("frame_done", FRAME_DONE, fd_exp);
      chk_bit("win_valid", WIN_VALID, new_pend || hold_pend);
      if (FRAME_DONE) fd_cnt++;
      if (new_pend) chk_win("win_latency", Feature_out, new_val);
      if (hold_pend) chk_win("win_hold", Feature_out, hold_val);
      if (WIN_VALID && WIN_READY) begin
        got_q.push_back(Feature_out);
        if (exp_q.size() == 0) begin
          chk_bit("spurious_window", 1'b1, 1'b0);
        end else begin
          w   = exp_q.pop_front();
          lst = exp_last_q.pop_front();
          chk_win("window", Feature_out, w);
`ifdef WINDOW_3_3_GEN_WIN_LAST_EN
          chk_bit("win_last", WIN_LAST, lst);
`endif
        end
      end
      hold_pend = WIN_VALID && !WIN_READY;
      hold_val  = Feature_out;
      new_pend  = 0;
      fd_exp    = 0;
      if (PIX_VALID && PIX_READY) begin
        img[m_row][m_col] = PIX_DATA;
        if (m_row >= 2 && m_col >= 2) begin
          w = '0;
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              w[DW*(r*3+c) +: DW] = img[m_row-2+r][m_col-2+c];
          exp_q.push_back(w);
          exp_last_q.push_back(m_row == IH-1 && m_col == IW-1);
          new_pend = 1;
          new_val  = w;
        end
        if (m_row == IH-1 && m_col == IW-1) fd_exp = 1;
        m_col++;
        if (m_col == IW) begin
          m_col = 0;
          m_row = (m_row + 1) % IH;
        end
      end
    end
  end

  // Driver tasks
  task automatic do_reset();
    RST = 1'b1;
    PIX_VALID = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input bit rnd);
    bit acc;
    int budget;
    if (rnd) begin
      repeat ($urandom_range(0, 2)) begin
        PIX_VALID = 1'b0;
        WIN_READY = 1'($urandom_range(0, 1));
        @(posedge CLK);
        #1;
      end
    end
    PIX_VALID = 1'b1;
    PIX_DATA  = d;
    budget    = 0;
    forever begin
      if (rnd) WIN_READY = 1'($urandom_range(0, 1));
      @(negedge CLK);
      acc = PIX_READY;
      @(posedge CLK);
      #1;
      if (acc) break;
      budget++;
      if (budget > 60) begin
        chk_bit("accept_timeout", 1'b1, 1'b0);
        break;
      end
    end
    PIX_VALID = 1'b0;
  endtask

  task automatic send_range(input int first, input int last, input bit rnd);
    for (int v = first; v <= last; v++) send(DW'(v), rnd);
  endtask

  task automatic drain();
    PIX_VALID = 1'b0;
    WIN_READY = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
  endtask

  localparam logic [FW-1:0] FIRST_WIN  = 72'h0B0A09070605030201;
  localparam logic [FW-1:0] LAST_WIN   = 72'h100F0E0C0B0A080706;
  localparam logic [FW-1:0] F2_FIRST   = 72'h1B1A19171615131211;

  // Directed steps
  initial begin
    PIX_DATA  = '0;
    WIN_READY = 1'b1;
    do_reset();

    // Plain frame 1..16 with downstream always ready
    got_q.delete();
    fd_cnt = 0;
    send_range(1, 16, 0);
    drain();
    chk_win("f1_count", FW'(got_q.size()), FW'(4));
    if (got_q.size() == 4) begin
      chk_win("f1_first", got_q[0], FIRST_WIN);
      chk_win("f1_last", got_q[3], LAST_WIN);
    end
    chk_win("f1_frame_done_cnt", FW'(fd_cnt), FW'(1));

    // Downstream stall of 5 cycles on the first window
    got_q.delete();
    WIN_READY = 1'b0;
    send_range(1, 11, 0);
    PIX_VALID = 1'b1;
    PIX_DATA  = 8'd12;
    repeat (5) begin
      @(negedge CLK);
      chk_bit("stall_pix_ready", PIX_READY, 1'b0);
      chk_win("stall_feature", Feature_out, FIRST_WIN);
      @(posedge CLK);
      #1;
    end
    WIN_READY = 1'b1;
    send_range(12, 16, 0);
    drain();
    chk_win("stall_count", FW'(got_q.size()), FW'(4));
    if (got_q.size() == 4) begin
      chk_win("stall_first", got_q[0], FIRST_WIN);
      chk_win("stall_last", got_q[3], LAST_WIN);
    end

    // Back-to-back frames without idle cycles
    got_q.delete();
    fd_cnt = 0;
    send_range(1, 32, 0);
    drain();
    chk_win("b2b_count", FW'(got_q.size()), FW'(8));
    if (got_q.size() == 8) chk_win("b2b_f2_first", got_q[4], F2_FIRST);
    chk_win("b2b_frame_done_cnt", FW'(fd_cnt), FW'(2));

    // Reset in the middle of a frame
    send_range(1, 9, 0);
    do_reset();
    got_q.delete();
    fd_cnt = 0;
    send_range(1, 16, 0);
    drain();
    chk_win("rst_mid_count", FW'(got_q.size()), FW'(4));
    if (got_q.size() == 4) begin
      chk_win("rst_mid_first", got_q[0], FIRST_WIN);
      chk_win("rst_mid_last", got_q[3], LAST_WIN);
    end
    chk_win("rst_mid_frame_done_cnt", FW'(fd_cnt), FW'(1));

    // Randomized data with random source and sink gaps
    got_q.delete();
    fd_cnt = 0;
    for (int f = 0; f < 4; f++)
      for (int p = 0; p < IW*IH; p++)
        send(DW'($urandom), 1);
    drain();
    chk_win("rand_count", FW'(got_q.size()), FW'(16));
    chk_win("rand_queue_empty", FW'(exp_q.size()), FW'(0));
    chk_win("rand_frame_done_cnt", FW'(fd_cnt), FW'(4));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
